adc_to_opfb_hls_deadlock_report_ctrl: RTL and testbench

//  Controller on the other end of the per-process deadlock detect units. Collects each unit's
//  dl_detect_out and confirms a persistent detection. Drives a one-hot origin pulse and the

---
 rtl/adc_to_opfb_hls_deadlock_pkg.sv | 22 ++
 rtl/adc_to_opfb_hls_deadlock_prio_enc.sv | 20 ++
 rtl/adc_to_opfb_hls_deadlock_report_ctrl.sv | 149 ++++++++++++++
 tb/tb_adc_to_opfb_hls_deadlock_report_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_to_opfb_hls_deadlock_pkg.sv
// Definitions shared by the deadlock report controller and the per-process detect units.
package adc_to_opfb_hls_deadlock_pkg;

  localparam int PROC_NUM_DEFAULT = 4;
  localparam int STATE_W          = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_TRACE   = 2'd2,
    ST_REPORT  = 2'd3
  } ctrl_state_e;

  // Bit width needed to index/count 'value' items, never below 1.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/adc_to_opfb_hls_deadlock_prio_enc.sv
// Lowest-index priority encoder: picks the first process reporting a detect.
module adc_to_opfb_hls_deadlock_prio_enc #(
  parameter int PROC_NUM = 4,
  parameter int PID_W    = 2
) (
  input  logic [PROC_NUM-1:0] req_i,
  output logic [PID_W-1:0]    idx_o,
  output logic                valid_o
);

  // Scanning downward lets the lowest set index overwrite higher ones.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = PID_W'(i);
    end
  end

endmodule

// File: rtl/adc_to_opfb_hls_deadlock_report_ctrl.sv
// Confirms a persistent deadlock detect, pulses the origin, traces the token loop,
// clears the token and holds a report of the deadlocked process until acknowledged.
module adc_to_opfb_hls_deadlock_report_ctrl
  import adc_to_opfb_hls_deadlock_pkg::*;
#(
  parameter int  PROC_NUM       = PROC_NUM_DEFAULT,
  parameter int  CONFIRM_CYCLES = 16,
  parameter int  TRACE_TIMEOUT  = 64,
  localparam int PID_W          = clog2_min1(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_seen_vec,
  input  logic                report_ack,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                dl_detect_fb,
  output logic                report_valid,
  output logic [PID_W-1:0]    report_proc_id,
  output logic [PROC_NUM-1:0] report_path,
  output logic                report_timeout
);

  localparam int CNT_W  = clog2_min1(CONFIRM_CYCLES);
  localparam int TCNT_W = clog2_min1(TRACE_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TRACE_TIMEOUT - 1);

  ctrl_state_e         state_q, state_d;
  logic [PID_W-1:0]    cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [PROC_NUM-1:0] origin_q, origin_d;
  logic [PROC_NUM-1:0] path_q, path_d;
  logic                fb_q, fb_d;
  logic                timeout_q, timeout_d;

  logic [PID_W-1:0]    enc_idx;
  logic                enc_valid;
  logic [PROC_NUM-1:0] cand_onehot;
  logic                cand_detect;
  logic                loop_closed;
  logic                tcnt_last;

  adc_to_opfb_hls_deadlock_prio_enc #(
    .PROC_NUM (PROC_NUM),
    .PID_W    (PID_W)
  ) u_prio_enc (
    .req_i   (dl_detect_vec),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign cand_onehot = PROC_NUM'(1) << cand_q;
  assign cand_detect = dl_detect_vec[cand_q];
  assign loop_closed = cand_detect && (tcnt_q != '0);
  assign tcnt_last   = (tcnt_q == TCNT_LAST);

  // NOTE: every next-state value gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    origin_d    = '0;
    path_d      = path_q;
    fb_d        = fb_q;
    timeout_d   = timeout_q;
    token_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          cand_d  = enc_idx;
          cnt_d   = '0;
          state_d = ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        if (!cand_detect) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_TRACE;
          origin_d = cand_onehot;
          fb_d     = 1'b1;
          tcnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TRACE: begin
        path_d      = path_q | token_seen_vec;
        token_clear = loop_closed || tcnt_last;
        // Closure is tested first so it wins a tie with the timeout.
        if (loop_closed) begin
          path_d    = path_q | token_seen_vec | cand_onehot;
          timeout_d = 1'b0;
          state_d   = ST_REPORT;
        end else if (tcnt_last) begin
          timeout_d = 1'b1;
          state_d   = ST_REPORT;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      ST_REPORT: begin
        if (report_ack) begin
          state_d   = ST_IDLE;
          fb_d      = 1'b0;
          path_d    = '0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      origin_q  <= '0;
      path_q    <= '0;
      fb_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      origin_q  <= origin_d;
      path_q    <= path_d;
      fb_q      <= fb_d;
      timeout_q <= timeout_d;
    end
  end

  // Report fields read as zero whenever no report is being presented.
  assign origin_vec     = origin_q;
  assign dl_detect_fb   = fb_q;
  assign report_valid   = (state_q == ST_REPORT);
  assign report_proc_id = report_valid ? cand_q : '0;
  assign report_path    = report_valid ? path_q : '0;
  assign report_timeout = report_valid && timeout_q;

endmodule

// File: tb/tb_adc_to_opfb_hls_deadlock_report_ctrl.sv
// Self-checking bench for the deadlock report controller: directed scenarios plus random transactions.
module tb_adc_to_opfb_hls_deadlock_report_ctrl;

  localparam int N  = 4;
  localparam int CC = 4;
  localparam int TT = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] dl_detect_vec;
  logic [N-1:0] token_seen_vec;
  logic         report_ack;
  logic [N-1:0] origin_vec;
  logic         token_clear;
  logic         dl_detect_fb;
  logic         report_valid;
  logic [1:0]   report_proc_id;
  logic [N-1:0] report_path;
  logic         report_timeout;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] tok_seq [TT];

  always #5 clock = ~clock;

  adc_to_opfb_hls_deadlock_report_ctrl #(
    .PROC_NUM       (N),
    .CONFIRM_CYCLES (CC),
    .TRACE_TIMEOUT  (TT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dl_detect_vec  (dl_detect_vec),
    .token_seen_vec (token_seen_vec),
    .report_ack     (report_ack),
    .origin_vec     (origin_vec),
    .token_clear    (token_clear),
    .dl_detect_fb   (dl_detect_fb),
    .report_valid   (report_valid),
    .report_proc_id (report_proc_id),
    .report_path    (report_path),
    .report_timeout (report_timeout)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] o, input logic fb, input logic tc,
                            input logic v, input logic [1:0] id, input logic [N-1:0] p, input logic to);
    check({tag, ".origin"},  32'(origin_vec),     32'(o));
    check({tag, ".fb"},      32'(dl_detect_fb),   32'(fb));
    check({tag, ".tclear"},  32'(token_clear),    32'(tc));
    check({tag, ".valid"},   32'(report_valid),   32'(v));
    check({tag, ".id"},      32'(report_proc_id), 32'(id));
    check({tag, ".path"},    32'(report_path),    32'(p));
    check({tag, ".timeout"}, 32'(report_timeout), 32'(to));
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic apply(input logic [N-1:0] d, input logic [N-1:0] t, input logic a);
    dl_detect_vec  = d;
    token_seen_vec = t;
    report_ack     = a;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  // One detect transaction checked against a transaction-level expectation:
  // cand = lowest set bit of det, origin pulse at cycle CC+1, path = union of tokens
  // (plus the origin when the loop closes), timeout when no closure by tcnt TT-1.
  // close_at = 0 or >= TT means the loop never closes; abort_at >= 0 asserts reset at that tcnt.
  task automatic run_txn(input string tag, input logic [N-1:0] det, input int close_at,
                         input int ack_delay, input bit noise, input int abort_at);
    logic [N-1:0] oh, path, d;
    int           cand;
    bit           closed;
    cand = 0;
    for (int i = N - 1; i >= 0; i--) if (det[i]) cand = i;
    oh     = N'(1) << cand;
    path   = '0;
    closed = 1'b0;

    apply(det, N'($urandom), noise ? 1'($urandom) : 1'b0);
    check_outs({tag, ".c0"}, '0, 0, 0, 0, 0, '0, 0);
    next_cycle();
    for (int c = 1; c <= CC; c++) begin
      d = noise ? ((N'($urandom) & ~oh) | oh) : det;
      apply(d, N'($urandom), noise ? 1'($urandom) : 1'b0);
      check_outs({tag, ".confirm"}, '0, 0, 0, 0, 0, '0, 0);
      next_cycle();
    end

    for (int t = 0; t < TT; t++) begin
      d = noise ? (N'($urandom) & ~oh) : (det & ~oh);
      if (t == 0 || t == close_at) d = d | oh;
      apply(d, tok_seq[t], noise ? 1'($urandom) : 1'b0);
      if (t == abort_at) begin
        reset = 1'b0;
        #1;
        check_outs({tag, ".abort"}, '0, 0, 0, 0, 0, '0, 0);
        next_cycle();
        apply(N'($urandom), N'($urandom), 1'($urandom));
        check_outs({tag, ".inreset"}, '0, 0, 0, 0, 0, '0, 0);
        next_cycle();
        reset = 1'b1;
        apply('0, '0, 1'b0);
        check_outs({tag, ".release"}, '0, 0, 0, 0, 0, '0, 0);
        next_cycle();
        return;
      end
      closed = (t == close_at) && (t != 0);
      path   = path | tok_seq[t];
      check_outs({tag, ".trace"}, (t == 0) ? oh : '0, 1, closed || (t == TT - 1), 0, 0, '0, 0);
      next_cycle();
      if (closed || t == TT - 1) break;
    end
    if (closed) path = path | oh;

    for (int k = 0; k < ack_delay; k++) begin
      apply(noise ? N'($urandom) : '0, N'($urandom), 1'b0);
      check_outs({tag, ".report"}, '0, 1, 0, 1, 2'(cand), path, !closed);
      next_cycle();
    end
    apply(N'($urandom), N'($urandom), 1'b1);
    check_outs({tag, ".ackcyc"}, '0, 1, 0, 1, 2'(cand), path, !closed);
    next_cycle();
    apply('0, '0, 1'b0);
    check_outs({tag, ".after"}, '0, 0, 0, 0, 0, '0, 0);
    next_cycle();
  endtask

  initial begin
    reset = 1'b0;
    apply('0, '0, 1'b0);
    next_cycle();

    // Reset held low with random inputs: everything stays at zero.
    for (int c = 0; c < 6; c++) begin
      apply(N'($urandom), N'($urandom), 1'($urandom));
      check_outs("reset", '0, 0, 0, 0, 0, '0, 0);
      next_cycle();
    end
    reset = 1'b1;
    apply('0, '0, 1'b0);
    check_outs("release", '0, 0, 0, 0, 0, '0, 0);
    next_cycle();

    // Transient detect drops out of CONFIRM without side effects.
    for (int c = 0; c < 10; c++) begin
      apply((c < 3) ? 4'b0100 : 4'b0000, 4'b0000, 1'b0);
      check_outs("transient", '0, 0, 0, 0, 0, '0, 0);
      next_cycle();
    end

    // Full loop: tokens at 1 and 3, closure at tcnt 3 -> path 1110.
    foreach (tok_seq[i]) tok_seq[i] = '0;
    tok_seq[1] = 4'b0010;
    tok_seq[2] = 4'b1000;
    run_txn("full", 4'b0100, 3, 2, 1'b0, -1);

    // Multiple detects: lowest index wins.
    foreach (tok_seq[i]) tok_seq[i] = N'($urandom);
    run_txn("multi", 4'b1010, 2, 1, 1'b0, -1);

    // Timeout with report held for 10 cycles before ack.
    foreach (tok_seq[i]) tok_seq[i] = '0;
    tok_seq[0] = 4'b0001;
    tok_seq[4] = 4'b0100;
    tok_seq[7] = 4'b1000;
    run_txn("timeout", 4'b0010, 0, 10, 1'b1, -1);

    // Closure exactly at the last trace cycle wins over the timeout.
    foreach (tok_seq[i]) tok_seq[i] = N'($urandom);
    run_txn("tie", 4'b1000, TT - 1, 0, 1'b1, -1);

    // Async reset mid-trace, then a fresh transaction that must restart cleanly.
    foreach (tok_seq[i]) tok_seq[i] = 4'b1111;
    run_txn("abort", 4'b0100, 5, 0, 1'b0, 3);
    foreach (tok_seq[i]) tok_seq[i] = '0;
    tok_seq[2] = 4'b0100;
    run_txn("restart", 4'b0001, 3, 1, 1'b0, -1);

    // Random transactions.
    for (int n = 0; n < 16; n++) begin
      foreach (tok_seq[i]) tok_seq[i] = N'($urandom);
      run_txn("rand", N'($urandom_range(1, 15)), int'($urandom_range(0, TT + 1)),
              int'($urandom_range(0, 4)), 1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
